// File: rtl/mem_burst_pkg.sv
// Shared constants, state encoding and address helper for the 4-beat,
// 64-bit burst memory responder.
package mem_burst_pkg;

  localparam int BEAT_W = 64;
  localparam int LINE_W = 256;
  localparam int BEATS  = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_RD_BEAT = 2'd2,
    ST_WR_BEAT = 2'd3
  } state_e;

  function automatic logic [31:0] line_addr(input logic [31:0] addr);
    return {addr[31:5], 5'h0};
  endfunction

endpackage

// File: rtl/burst_mem_responder_line_ram.sv
// Line storage: 2**IDX_W lines of 256 bits, per-64-bit-word write enables,
// combinational read. Contents are deliberately not reset.
module line_ram
  import mem_burst_pkg::*;
#(
  parameter int IDX_W = 8
) (
  input  logic              clk,
  input  logic [BEATS-1:0]  we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [BEAT_W-1:0] wdata,
  input  logic [IDX_W-1:0]  ridx,
  output logic [LINE_W-1:0] rline
);

  logic [LINE_W-1:0] mem [2**IDX_W];

  always_ff @(posedge clk) begin
    for (int w = 0; w < BEATS; w++) begin
      if (we[w]) mem[widx][w*BEAT_W +: BEAT_W] <= wdata;
    end
  end

  assign rline = mem[ridx];

endmodule

// File: rtl/burst_mem_responder.sv
// Burst memory responder: accepts line reads/writes over the 4-beat, 64-bit
// burst protocol and serves one burst at a time from a local line array.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | ready for a new read or write request
//   ST_RD_WAIT | read accepted, line captured, counting down to first beat
//   ST_RD_BEAT | driving read beats 0..3; beat 3 may accept the next request
//   ST_WR_BEAT | collecting write beats 1..3; bmem_write=0 stalls
module burst_mem_responder
  import mem_burst_pkg::*;
#(
  parameter int IDX_W  = 8,
  parameter int RD_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] bmem_addr,
  input  logic        bmem_read,
  input  logic        bmem_write,
  input  logic [63:0] bmem_wdata,
  output logic        bmem_ready,
  output logic [31:0] bmem_raddr,
  output logic [63:0] bmem_rdata,
  output logic        bmem_rvalid
);

  localparam int LAT_W = $clog2(RD_LAT + 1);

  state_e              state;
  logic [1:0]          beat_cnt;
  logic [LAT_W-1:0]    lat_cnt;
  logic [LINE_W-1:0]   line_buf;
  logic [IDX_W-1:0]    wr_idx_q;
  logic [IDX_W-1:0]    req_idx;
  logic [BEATS-1:0]    ram_we;
  logic [IDX_W-1:0]    ram_widx;
  logic [LINE_W-1:0]   ram_rline;
  logic [1:0]          next_beat;
  logic                last_beat;
  logic                can_accept;
  logic                rd_acc;
  logic                wr_acc;

  assign req_idx    = bmem_addr[5+IDX_W-1:5];
  assign last_beat  = (state == ST_RD_BEAT) && (beat_cnt == 2'd3);
  assign bmem_ready = (state == ST_IDLE) || (state == ST_WR_BEAT) || last_beat;
  assign can_accept = (state == ST_IDLE) || last_beat;
  assign rd_acc     = can_accept && bmem_read;
  assign wr_acc     = can_accept && bmem_write && !bmem_read;
  assign next_beat  = beat_cnt + 2'd1;

  always_comb begin
    ram_we   = '0;
    ram_widx = req_idx;
    if (wr_acc) begin
      ram_we[0] = 1'b1;
    end else if ((state == ST_WR_BEAT) && bmem_write) begin
      ram_we[beat_cnt] = 1'b1;
      ram_widx         = wr_idx_q;
    end
  end

  line_ram #(.IDX_W(IDX_W)) u_line_ram (
    .clk   (clk),
    .we    (ram_we),
    .widx  (ram_widx),
    .wdata (bmem_wdata),
    .ridx  (req_idx),
    .rline (ram_rline)
  );

  // The whole line is captured at accept so later writes cannot alter a burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      beat_cnt    <= '0;
      lat_cnt     <= '0;
      line_buf    <= '0;
      wr_idx_q    <= '0;
      bmem_raddr  <= '0;
      bmem_rdata  <= '0;
      bmem_rvalid <= 1'b0;
    end else if (rd_acc) begin
      line_buf   <= ram_rline;
      bmem_raddr <= line_addr(bmem_addr);
      beat_cnt   <= '0;
      if (RD_LAT == 1) begin
        state       <= ST_RD_BEAT;
        bmem_rvalid <= 1'b1;
        bmem_rdata  <= ram_rline[BEAT_W-1:0];
        lat_cnt     <= '0;
      end else begin
        state       <= ST_RD_WAIT;
        bmem_rvalid <= 1'b0;
        lat_cnt     <= LAT_W'(RD_LAT - 1);
      end
    end else if (wr_acc) begin
      state       <= ST_WR_BEAT;
      beat_cnt    <= 2'd1;
      wr_idx_q    <= req_idx;
      bmem_rvalid <= 1'b0;
    end else begin
      case (state)
        ST_RD_WAIT: begin
          if (lat_cnt <= LAT_W'(1)) begin
            state       <= ST_RD_BEAT;
            bmem_rvalid <= 1'b1;
            bmem_rdata  <= line_buf[BEAT_W-1:0];
            lat_cnt     <= '0;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        ST_RD_BEAT: begin
          if (beat_cnt == 2'd3) begin
            state       <= ST_IDLE;
            bmem_rvalid <= 1'b0;
            beat_cnt    <= '0;
          end else begin
            beat_cnt   <= next_beat;
            bmem_rdata <= line_buf[next_beat*BEAT_W +: BEAT_W];
          end
        end
        ST_WR_BEAT: begin
          if (bmem_write) begin
            if (beat_cnt == 2'd3) begin
              state    <= ST_IDLE;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= next_beat;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_burst_mem_responder.sv
// Directed + randomized bench for burst_mem_responder against a line-level
// model (associative array of 256-bit lines keyed by line index).
module tb_burst_mem_responder;

  localparam int IDX_W  = 8;
  localparam int RD_LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] bmem_addr;
  logic        bmem_read;
  logic        bmem_write;
  logic [63:0] bmem_wdata;
  logic        bmem_ready;
  logic [31:0] bmem_raddr;
  logic [63:0] bmem_rdata;
  logic        bmem_rvalid;

  int errors = 0;
  int checks = 0;

  logic [255:0] mdl [int];
  logic [31:0]  written [$];

  burst_mem_responder #(.IDX_W(IDX_W), .RD_LAT(RD_LAT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bmem_addr   (bmem_addr),
    .bmem_read   (bmem_read),
    .bmem_write  (bmem_write),
    .bmem_wdata  (bmem_wdata),
    .bmem_ready  (bmem_ready),
    .bmem_raddr  (bmem_raddr),
    .bmem_rdata  (bmem_rdata),
    .bmem_rvalid (bmem_rvalid)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] a);
    return int'(a[5+IDX_W-1:5]);
  endfunction

  function automatic logic [255:0] rnd_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
    return l;
  endfunction

  // stall_b2 forces a stall before beat 2; other beats stall up to max_stall cycles
  task automatic write_line(input logic [31:0] a, input logic [255:0] d,
                            input int stall_b2, input int max_stall);
    int s;
    @(negedge clk);
    chk("wr_ready_idle", 64'(bmem_ready), 64'd1);
    bmem_write = 1'b1;
    bmem_addr  = a;
    bmem_wdata = d[63:0];
    for (int b = 1; b < 4; b++) begin
      @(posedge clk);
      @(negedge clk);
      s = (b == 2 && stall_b2 > 0) ? stall_b2 : int'($urandom_range(max_stall));
      if (s > 0) begin
        bmem_write = 1'b0;
        bmem_addr  = $urandom;
        bmem_wdata = {$urandom, $urandom};
        repeat (s) begin
          @(posedge clk);
          @(negedge clk);
          chk("wr_stall_ready", 64'(bmem_ready), 64'd1);
        end
      end
      bmem_write = 1'b1;
      bmem_addr  = $urandom;
      bmem_wdata = d[64*b +: 64];
    end
    @(posedge clk);
    @(negedge clk);
    bmem_write = 1'b0;
    chk("wr_done_ready", 64'(bmem_ready), 64'd1);
    chk("wr_done_rvalid", 64'(bmem_rvalid), 64'd0);
    mdl[idx_of(a)] = d;
    written.push_back(a);
  endtask

  // Entered just after the accepting posedge. With chain=1 read stays high and
  // a_next is presented in the beat-3 cycle.
  task automatic expect_burst(input logic [31:0] a, input bit chain, input logic [31:0] a_next);
    int lat;
    logic [255:0] line;
    line = mdl[idx_of(a)];
    @(negedge clk);
    lat = 1;
    bmem_write = 1'b0;
    if (!chain) bmem_read = 1'b0;
    while (!bmem_rvalid && lat < 20) begin
      chk("rd_wait_ready", 64'(bmem_ready), 64'd0);
      @(negedge clk);
      lat++;
    end
    chk("rd_latency", 64'(lat), 64'(RD_LAT));
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      chk("rd_rvalid", 64'(bmem_rvalid), 64'd1);
      chk("rd_rdata", bmem_rdata, line[64*k +: 64]);
      chk("rd_raddr", 64'(bmem_raddr), 64'({a[31:5], 5'h0}));
      chk("rd_ready", 64'(bmem_ready), (k == 3) ? 64'd1 : 64'd0);
    end
    if (chain) begin
      bmem_addr = a_next;
    end else begin
      @(negedge clk);
      chk("rd_end_rvalid", 64'(bmem_rvalid), 64'd0);
      chk("rd_end_ready", 64'(bmem_ready), 64'd1);
    end
  endtask

  task automatic read_line(input logic [31:0] a);
    @(negedge clk);
    chk("rd_ready_idle", 64'(bmem_ready), 64'd1);
    bmem_read = 1'b1;
    bmem_addr = a;
    @(posedge clk);
    expect_burst(a, 1'b0, 32'h0);
  endtask

  initial begin
    logic [255:0] d;
    logic [31:0]  a;
    logic [31:0]  r;

    rst_n      = 1'b0;
    bmem_addr  = '0;
    bmem_read  = 1'b0;
    bmem_write = 1'b0;
    bmem_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(bmem_ready), 64'd1);
    chk("rst_rvalid", 64'(bmem_rvalid), 64'd0);
    chk("rst_rdata", bmem_rdata, 64'd0);
    chk("rst_raddr", 64'(bmem_raddr), 64'd0);
    rst_n = 1'b1;

    // Basic write then read at an offset within the same line
    d = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
         64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    write_line(32'h0000_1000, d, 0, 0);
    read_line(32'h0000_1010);

    // Write with a 3-cycle stall after beat 1, junk data on the bus meanwhile
    write_line(32'h0000_2000, rnd_line(), 3, 0);
    read_line(32'h0000_2000);

    // Back-to-back reads: read held through RD_WAIT (ignored), accepted at beat 3
    @(negedge clk);
    bmem_read = 1'b1;
    bmem_addr = 32'h0000_1000;
    @(posedge clk);
    expect_burst(32'h0000_1000, 1'b1, 32'h0000_2000);
    @(posedge clk);
    expect_burst(32'h0000_2000, 1'b0, 32'h0);

    // Read and write together in IDLE: read wins, array untouched
    @(negedge clk);
    chk("rw_ready_idle", 64'(bmem_ready), 64'd1);
    bmem_read  = 1'b1;
    bmem_write = 1'b1;
    bmem_addr  = 32'h0000_2000;
    bmem_wdata = 64'hDEAD_BEEF_DEAD_BEEF;
    @(posedge clk);
    expect_burst(32'h0000_2000, 1'b0, 32'h0);
    read_line(32'h0000_2000);

    // Randomized writes with stalls, reads through aliased upper address bits
    for (int it = 0; it < 10; it++) begin
      a = {$urandom_range(255, 0) << 13} | ($urandom_range(255, 0) << 5) | $urandom_range(31, 0);
      write_line(a, rnd_line(), 0, 2);
      a = written[$urandom_range(written.size() - 1)];
      r = {19'($urandom), a[12:5], 5'($urandom)};
      read_line(r);
    end

    // Asynchronous reset in the middle of a read burst
    d = mdl[idx_of(32'h0000_1000)];
    @(negedge clk);
    bmem_read = 1'b1;
    bmem_addr = 32'h0000_1000;
    @(posedge clk);
    @(negedge clk);
    bmem_read = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_rst_beat1", bmem_rdata, d[127:64]);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_rvalid", 64'(bmem_rvalid), 64'd0);
    chk("mid_rst_ready", 64'(bmem_ready), 64'd1);
    chk("mid_rst_rdata", bmem_rdata, 64'd0);
    chk("mid_rst_raddr", 64'(bmem_raddr), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("post_rst_rvalid", 64'(bmem_rvalid), 64'd0);
    end
    read_line(32'h0000_1000);
    read_line(32'h0000_2000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
